// File: rtl/systolic_mm_stream.sv
// Output-stationary ROWS x COLS systolic matrix multiplier with streamed operands and rows out.
// Define SYSTOLIC_MM_SAT_EN to saturate results to OUT_W instead of truncating them.
module systolic_mm_stream #(
  parameter int DATA_W = 16,
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int K_MAX  = 64,
  parameter int ACC_W  = 48,
  parameter int OUT_W  = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [$clog2(K_MAX+1)-1:0]    k_len,
  input  logic                          signed_mode,
  input  logic                          acc_en,
  output logic                          busy,
  output logic                          done,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [ROWS*DATA_W-1:0]        a_col,
  input  logic [COLS*DATA_W-1:0]        b_row,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [COLS*OUT_W-1:0]         res_row,
  output logic [$clog2(ROWS)-1:0]       res_row_idx
);

  localparam int KW = $clog2(K_MAX+1);
  localparam int DRW = $clog2(ROWS+COLS);
  localparam int CW = (KW > DRW) ? KW : DRW;
  localparam int RW = $clog2(ROWS);

  typedef enum logic [1:0] {IDLE, FEED, DRAIN, OUT} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [KW-1:0]   klen_q, klen_d, klen_clamp;
  logic            mode_q, mode_d;
  logic [RW-1:0]   row_q, row_d;
  logic            done_q, done_d;
  logic            beat, acc_clr;

  logic [DATA_W-1:0] a_sk [ROWS];
  logic [DATA_W-1:0] b_sk [COLS];
  logic [DATA_W-1:0] a_in [ROWS][COLS];
  logic [DATA_W-1:0] b_in [ROWS][COLS];
  logic [DATA_W-1:0] a_q  [ROWS][COLS-1];
  logic [DATA_W-1:0] b_q  [ROWS-1][COLS];
  logic [ACC_W-1:0]  acc_q [ROWS][COLS];

  function automatic logic [ACC_W-1:0] mac_prod(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b,
                                                input logic sgn);
    logic signed [DATA_W:0]     ax, bx;
    logic signed [2*DATA_W+1:0] p;
    ax = sgn ? {a[DATA_W-1], a} : {1'b0, a};
    bx = sgn ? {b[DATA_W-1], b} : {1'b0, b};
    p  = (2*DATA_W+2)'(ax) * (2*DATA_W+2)'(bx);
    return ACC_W'(p);
  endfunction

`ifdef SYSTOLIC_MM_SAT_EN
  localparam logic [ACC_W-1:0] SMAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] SMIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
  localparam logic [ACC_W-1:0] UMAX = {{(ACC_W-OUT_W){1'b0}}, {OUT_W{1'b1}}};

  function automatic logic [OUT_W-1:0] sat_out(input logic [ACC_W-1:0] acc, input logic sgn);
    logic [OUT_W-1:0] r;
    r = acc[OUT_W-1:0];
    if (sgn) begin
      if ($signed(acc) > $signed(SMAX))      r = SMAX[OUT_W-1:0];
      else if ($signed(acc) < $signed(SMIN)) r = SMIN[OUT_W-1:0];
    end else if (acc > UMAX) begin
      r = UMAX[OUT_W-1:0];
    end
    return r;
  endfunction
`endif

  assign klen_clamp = (k_len > KW'(K_MAX)) ? KW'(K_MAX) : k_len;
  assign beat       = (state_q == FEED) && in_valid;
  assign acc_clr    = (state_q == IDLE) && start && !acc_en;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    klen_d  = klen_q;
    mode_d  = mode_q;
    row_d   = row_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: if (start) begin
        klen_d  = klen_clamp;
        mode_d  = signed_mode;
        cnt_d   = '0;
        state_d = (klen_clamp == '0) ? DRAIN : FEED;
      end
      FEED: if (beat) begin
        if (cnt_q + CW'(1) == CW'(klen_q)) begin
          cnt_d   = '0;
          state_d = DRAIN;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DRAIN: if (cnt_q == CW'(ROWS+COLS-2)) begin
        cnt_d   = '0;
        row_d   = '0;
        state_d = OUT;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
      OUT: if (out_ready) begin
        if (row_q == RW'(ROWS-1)) begin
          row_d   = '0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          row_d = row_q + RW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      klen_q  <= '0;
      mode_q  <= 1'b0;
      row_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      klen_q  <= klen_d;
      mode_q  <= mode_d;
      row_q   <= row_d;
      done_q  <= done_d;
    end
  end

  // Input skew: lane n is delayed n cycles; idle or stalled cycles inject zeros
  for (genvar gi = 0; gi < ROWS; gi++) begin : g_askew
    logic [DATA_W-1:0] a_inj;
    assign a_inj = beat ? a_col[gi*DATA_W +: DATA_W] : '0;
    if (gi == 0) begin : g_d0
      assign a_sk[0] = a_inj;
    end else begin : g_dn
      logic [DATA_W-1:0] dly_q [gi];
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int d = 0; d < gi; d++) dly_q[d] <= '0;
        end else begin
          dly_q[0] <= a_inj;
          for (int d = 1; d < gi; d++) dly_q[d] <= dly_q[d-1];
        end
      end
      assign a_sk[gi] = dly_q[gi-1];
    end
  end

  for (genvar gj = 0; gj < COLS; gj++) begin : g_bskew
    logic [DATA_W-1:0] b_inj;
    assign b_inj = beat ? b_row[gj*DATA_W +: DATA_W] : '0;
    if (gj == 0) begin : g_d0
      assign b_sk[0] = b_inj;
    end else begin : g_dn
      logic [DATA_W-1:0] dly_q [gj];
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int d = 0; d < gj; d++) dly_q[d] <= '0;
        end else begin
          dly_q[0] <= b_inj;
          for (int d = 1; d < gj; d++) dly_q[d] <= dly_q[d-1];
        end
      end
      assign b_sk[gj] = dly_q[gj-1];
    end
  end

  for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
    for (genvar gj = 0; gj < COLS; gj++) begin : g_col
      if (gj == 0) begin : g_aw
        assign a_in[gi][0] = a_sk[gi];
      end else begin : g_an
        assign a_in[gi][gj] = a_q[gi][gj-1];
      end
      if (gi == 0) begin : g_bn
        assign b_in[0][gj] = b_sk[gj];
      end else begin : g_bs
        assign b_in[gi][gj] = b_q[gi-1][gj];
      end
    end
  end

  // PE grid: a moves right, b moves down, each PE accumulates in place
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ROWS; i++)
        for (int j = 0; j < COLS; j++) acc_q[i][j] <= '0;
      for (int i = 0; i < ROWS; i++)
        for (int j = 0; j < COLS-1; j++) a_q[i][j] <= '0;
      for (int i = 0; i < ROWS-1; i++)
        for (int j = 0; j < COLS; j++) b_q[i][j] <= '0;
    end else begin
      for (int i = 0; i < ROWS; i++)
        for (int j = 0; j < COLS; j++)
          acc_q[i][j] <= acc_clr ? '0 : acc_q[i][j] + mac_prod(a_in[i][j], b_in[i][j], mode_q);
      for (int i = 0; i < ROWS; i++)
        for (int j = 0; j < COLS-1; j++) a_q[i][j] <= a_in[i][j];
      for (int i = 0; i < ROWS-1; i++)
        for (int j = 0; j < COLS; j++) b_q[i][j] <= b_in[i][j];
    end
  end

  for (genvar gj = 0; gj < COLS; gj++) begin : g_res
`ifdef SYSTOLIC_MM_SAT_EN
    assign res_row[gj*OUT_W +: OUT_W] = sat_out(acc_q[row_q][gj], mode_q);
`else
    assign res_row[gj*OUT_W +: OUT_W] = acc_q[row_q][gj][OUT_W-1:0];
`endif
  end

  assign busy        = (state_q != IDLE);
  assign in_ready    = (state_q == FEED);
  assign out_valid   = (state_q == OUT);
  assign done        = done_q;
  assign res_row_idx = row_q;

endmodule

// File: doc/systolic_mm_stream.md
Name: systolic_mm_stream

Overview:
- Output-stationary ROWS x COLS systolic matrix-multiply engine. Computes C = A(ROWSxK) * B(KxCOLS), with K chosen at run time.
- Operands arrive as a valid/ready stream: one A column and one B row per beat. Results leave as a valid/ready stream, one C row per beat.
- Sits between the RISC-V core's matmul command/DMA logic and the register/memory writeback path.
- Successor of the fixed 2x2 whole-matrix-in engine. Adds a true PE grid, streaming I/O, runtime K, signed/unsigned mode and accumulate mode.

Parameters:
- DATA_W, 16, operand element width.
- ROWS, 4, PE rows (rows of A and C).
- COLS, 4, PE columns (columns of B and C).
- K_MAX, 64, maximum inner dimension. Sets the width of k_len, which is clog2(K_MAX+1).
- ACC_W, 48, per-PE accumulator width. Must be at least 2*DATA_W.
- OUT_W, 32, result element width on res_row. Must be no greater than ACC_W.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  command pulse. Sampled only in IDLE.
- k_len  in  clog2(K_MAX+1)  inner dimension K. Latched on start.
- signed_mode  in  1  1 = two's-complement operands. Latched on start.
- acc_en  in  1  1 = keep previous accumulators instead of clearing. Latched on start.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle pulse after the last result row is accepted.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  engine accepts a beat.
- a_col  in  ROWS*DATA_W  column k of A. Element i occupies bits [i*DATA_W +: DATA_W].
- b_row  in  COLS*DATA_W  row k of B. Element j occupies bits [j*DATA_W +: DATA_W].
- out_valid  out  1  result row valid.
- out_ready  in  1  consumer accepts the row.
- res_row  out  COLS*OUT_W  row r of C. Element j occupies bits [j*OUT_W +: OUT_W].
- res_row_idx  out  clog2(ROWS)  r.

Behaviour:
- Reset values: busy=0, done=0, in_ready=0, out_valid=0, res_row=0, res_row_idx=0, all accumulators 0, all skew/PE pipeline registers 0, state IDLE.
- FSM states are IDLE, FEED, DRAIN, OUT.
- IDLE to FEED: on start=1.
  - Latch k_len, signed_mode and acc_en.
  - If acc_en=0, clear all accumulators in the same edge.
  - Clear the beat counter.
- FEED:
  - in_ready=1.
  - A beat is accepted when in_valid && in_ready. Each accepted beat increments the counter.
  - The grid shifts every cycle. A cycle with no accepted beat injects zeros; stalls never corrupt results.
  - FEED to DRAIN: on the edge that accepts beat number k_len.
  - k_len=0: go directly IDLE to DRAIN. C equals the prior accumulators, or 0 if acc_en=0.
  - k_len>K_MAX is clamped to K_MAX.
- Skew:
  - A element i is delayed i cycles before entering PE(i,0).
  - B element j is delayed j cycles before entering PE(0,j).
  - Each PE registers a to the right and b downward.
- PE arithmetic:
  - acc <= acc + ext(a)*ext(b).
  - ext() is sign-extension when signed_mode=1 and zero-extension otherwise.
  - The product is 2*DATA_W bits, extended to ACC_W.
  - Accumulation wraps modulo 2^ACC_W.
- DRAIN: lasts exactly ROWS+COLS-1 cycles, during which zeros are injected. It then moves to OUT with r=0.
- OUT:
  - out_valid=1. res_row carries accumulator row r, converted to OUT_W per the Optional Feature.
  - A row is accepted on out_valid && out_ready. r increments; row ROWS-1 accepted moves the FSM to IDLE.
  - res_row and res_row_idx hold stable while out_valid && !out_ready.
  - done pulses on the cycle after the final row handshake (state is IDLE by then).
- start while busy=1 is ignored: no latch, no effect.
- Latency:
  - First out_valid rises ROWS+COLS-1 cycles after the last beat handshake.
  - With in_valid and out_ready held at 1, start to done takes 1+k_len+ROWS+COLS-1+ROWS cycles.
- Reset asserted mid-operation returns every output and register to its reset value immediately. Partial results are discarded.
- Accumulators persist across IDLE, so acc_en=1 chains K-blocks for K > K_MAX.

Optional Feature:
- Macro SYSTOLIC_MM_SAT_EN.
- Defined: each accumulator is saturated to OUT_W on output.
  - signed_mode=1: clamp to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - signed_mode=0: clamp to [0, 2^OUT_W-1].
  - Internal accumulators are never modified by saturation.
- Undefined: res_row elements are the low OUT_W bits of the accumulator (plain truncation).

Test Plan:
- Identity: ROWS=COLS=4, k_len=4, A=I, B=1..16 row-major, in_valid=1, out_ready=1 -> rows {1,2,3,4},{5,6,7,8},{9..12},{13..16}; done exactly 16 cycles after start.
- Signed: 2x2 slice, k_len=2, signed_mode=1, A=[[-1,2],[3,-4]], B=[[5,6],[7,8]] -> C=[[9,10],[-13,-14]]. Same operands with signed_mode=0 -> C00 = 65535*5+2*7 = 327689.
- Backpressure and stalls: k_len=3; in_valid toggles 1,0,0,1,0,1; out_ready low 3 cycles per row -> results equal the no-stall run; res_row stable while held; in_ready=0 outside FEED.
- Accumulate: run A*B, then start with acc_en=1 and the same operands -> C doubles. acc_en=0 run -> C back to 1x.
- Boundary: k_len=0 with acc_en=0 -> four zero rows, then done. start pulsed during FEED -> ignored. reset asserted mid-DRAIN -> busy=0, out_valid=0, accumulators 0 on the next sample.
- Saturation (SYSTOLIC_MM_SAT_EN, OUT_W=16): signed, k_len=2, all operands 0x7FFF -> 0x7FFF. Same stimulus without the macro -> low 16 bits of 2*0x3FFF0001 = 0x0002.
